// File: rtl/mem_burst_serializer_pkg.sv
// Shared definitions for the burst serializer: FSM states, default sizing and
// the index helpers that fix which element opens and closes a burst.
package mem_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int DEPTH_DEF  = 16;
  localparam int ADDR_W_DEF = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  function automatic int unsigned first_index(input logic desc, input int unsigned depth);
    return desc ? depth - 1 : 0;
  endfunction

  function automatic int unsigned final_index(input logic desc, input int unsigned depth);
    return desc ? 0 : depth - 1;
  endfunction

endpackage

// File: rtl/mem_burst_serializer_if.sv
// Burst-in / word-out bus of the serializer. The slave side is the serializer,
// the master side is whoever feeds bursts and drains words.
interface mem_burst_serializer_if import mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic                           in_valid;
  logic                           in_ready;
  logic [DEPTH-1:0][DATA_W-1:0]   in_data;
  logic [ADDR_W-1:0]              in_base_addr;
  logic                           in_desc;
  logic                           out_valid;
  logic                           out_ready;
  logic [DATA_W-1:0]              out_data;
  logic [ADDR_W-1:0]              out_addr;
  logic                           out_last;
  logic                           done;

  modport master (
    output in_valid, in_data, in_base_addr, in_desc, out_ready,
    input  in_ready, out_valid, out_data, out_addr, out_last, done
  );

  modport slave (
    input  in_valid, in_data, in_base_addr, in_desc, out_ready,
    output in_ready, out_valid, out_data, out_addr, out_last, done
  );

endinterface

// File: rtl/mem_burst_serializer.sv
// Captures a DEPTH-word burst and replays it one word per accepted beat with
// its memory address, ascending or descending. All state moves on the falling edge.
//
//   state | meaning
//   IDLE  | waiting for a burst, in_ready high
//   SEND  | replaying captured burst, one word per out_ready beat
module mem_burst_serializer import mem_pkg::*; #(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  mem_burst_serializer_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  typedef logic [IDX_W-1:0] idx_t;

  state_t state_q;
  state_t state_d;

  logic [DEPTH-1:0][DATA_W-1:0] vec_q;
  logic [ADDR_W-1:0]            base_q;
  logic                         desc_q;

  idx_t              idx_q;
  idx_t              idx_first;
  idx_t              idx_nxt;
  logic              nxt_is_last;
  logic              out_valid_q;
  logic              out_last_q;
  logic              done_q;
  logic [DATA_W-1:0] out_data_q;
  logic [ADDR_W-1:0] out_addr_q;

  logic accept;
  logic beat;
  logic finish;

  always_ff @(negedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    beat    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          accept  = 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (bus.out_ready) begin
          beat = 1'b1;
          if (out_last_q) begin
            finish  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = out_valid_q;
    bus.out_data  = out_data_q;
    bus.out_addr  = out_addr_q;
    bus.out_last  = out_last_q;
    bus.done      = done_q;
  end

  always_comb begin
    idx_first   = idx_t'(first_index(bus.in_desc, DEPTH));
    idx_nxt     = desc_q ? idx_q - idx_t'(1) : idx_q + idx_t'(1);
    nxt_is_last = (idx_nxt == idx_t'(final_index(desc_q, DEPTH)));
  end

  // Burst snapshot: only loaded on accept, so input changes during SEND are invisible.
  always_ff @(negedge clk) begin
    if (accept && !rst) begin
      vec_q  <= bus.in_data;
      base_q <= bus.in_base_addr;
      desc_q <= bus.in_desc;
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      done_q      <= 1'b0;
      out_data_q  <= '0;
      out_addr_q  <= '0;
    end else begin
      done_q <= finish;
      if (accept) begin
        // First word comes straight from the inputs so it is valid right after the accept edge.
        idx_q       <= idx_first;
        out_data_q  <= bus.in_data[idx_first];
        out_addr_q  <= bus.in_base_addr + ADDR_W'(idx_first);
        out_last_q  <= 1'b0;
        out_valid_q <= 1'b1;
      end else if (finish) begin
        out_valid_q <= 1'b0;
        out_last_q  <= 1'b0;
      end else if (beat) begin
        idx_q      <= idx_nxt;
        out_data_q <= vec_q[idx_nxt];
        out_addr_q <= base_q + ADDR_W'(idx_nxt);
        out_last_q <= nxt_is_last;
      end
    end
  end

endmodule

// File: tb/tb_mem_burst_serializer.sv
// Self-checking bench: expected beats are built from the burst rules (element
// order, base+index address) and compared word by word against the DUT.
module tb_mem_burst_serializer;

  localparam int DW = 16;
  localparam int DP = 16;
  localparam int AW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  mem_burst_serializer_if #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) bus ();
  mem_burst_serializer_if #(.DATA_W(DW), .DEPTH(4),  .ADDR_W(AW)) bus4 ();

  mem_burst_serializer #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  mem_burst_serializer #(.DATA_W(DW), .DEPTH(4), .ADDR_W(AW)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4.slave)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] vec [DP];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic drive_idle();
    bus.in_valid      = 1'b0;
    bus.in_data       = '0;
    bus.in_base_addr  = '0;
    bus.in_desc       = 1'b0;
    bus.out_ready     = 1'b0;
    bus4.in_valid     = 1'b0;
    bus4.in_data      = '0;
    bus4.in_base_addr = '0;
    bus4.in_desc      = 1'b0;
    bus4.out_ready    = 1'b0;
  endtask

  task automatic fill_ramp(input logic [DW-1:0] start);
    for (int i = 0; i < DP; i++) vec[i] = start + DW'(i);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DP; i++) vec[i] = DW'($urandom);
  endtask

  // Plays one burst: mode 0 = always ready, 1 = ready pattern 1,0,0,1, 2 = random.
  // hold keeps in_valid high with garbage inputs during SEND; abort_after>0 resets after that many beats.
  task automatic run_burst(input logic [AW-1:0] base, input logic desc, input int mode,
                           input bit hold, input int abort_after);
    logic [DW-1:0] exp_data [$];
    logic [AW-1:0] exp_addr [$];
    logic [AW-1:0] a;
    int            idx;
    int            popped = 0;
    int            cyc = 0;
    bit            r;
    for (int k = 0; k < DP; k++) begin
      idx = desc ? DP - 1 - k : k;
      a   = base + AW'(idx);
      exp_data.push_back(vec[idx]);
      exp_addr.push_back(a);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_ready: in_ready=%b expected 1", bus.in_ready);
    end
    bus.in_valid     = 1'b1;
    for (int i = 0; i < DP; i++) bus.in_data[i] = vec[i];
    bus.in_base_addr = base;
    bus.in_desc      = desc;
    bus.out_ready    = 1'b0;
    @(posedge clk);
    if (!hold) bus.in_valid = 1'b0;
    while (exp_data.size() > 0 && cyc < 20 * DP) begin
      if (hold) begin
        for (int i = 0; i < DP; i++) bus.in_data[i] = DW'($urandom);
        bus.in_base_addr = AW'($urandom);
        bus.in_desc      = ~desc;
      end
      checks++;
      if ({bus.out_valid, bus.out_last, bus.in_ready, bus.done, bus.out_addr, bus.out_data} !==
          {1'b1, (exp_data.size() == 1), 1'b0, 1'b0, exp_addr[0], exp_data[0]}) begin
        errors++;
        $display("FAIL beat%0d: got valid=%b last=%b in_ready=%b done=%b addr=%h data=%h, expected addr=%h data=%h last=%b",
                 popped, bus.out_valid, bus.out_last, bus.in_ready, bus.done, bus.out_addr,
                 bus.out_data, exp_addr[0], exp_data[0], (exp_data.size() == 1));
      end
      if (abort_after > 0 && popped == abort_after) begin
        rst           = 1'b1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        @(posedge clk);
        checks++;
        if ({bus.out_valid, bus.in_ready, bus.done, bus.out_last, bus.out_addr, bus.out_data} !==
            {1'b1 ^ 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000}) begin
          errors++;
          $display("FAIL mid_reset: got valid=%b in_ready=%b done=%b last=%b addr=%h data=%h, expected 0 1 0 0 0000 0000",
                   bus.out_valid, bus.in_ready, bus.done, bus.out_last, bus.out_addr, bus.out_data);
        end
        rst = 1'b0;
        return;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (r) begin
        void'(exp_data.pop_front());
        void'(exp_addr.pop_front());
        popped++;
      end
      cyc++;
      @(posedge clk);
    end
    checks++;
    if ({bus.done, bus.out_valid, bus.out_last, bus.in_ready} !== 4'b1001 || popped != DP) begin
      errors++;
      $display("FAIL done_pulse: got done=%b valid=%b last=%b in_ready=%b beats=%0d, expected 1 0 0 1 beats=%0d",
               bus.done, bus.out_valid, bus.out_last, bus.in_ready, popped, DP);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      @(posedge clk);
      checks++;
      if ({bus.done, bus.out_valid, bus.in_ready} !== 3'b001) begin
        errors++;
        $display("FAIL idle: got done=%b valid=%b in_ready=%b, expected 0 0 1",
                 bus.done, bus.out_valid, bus.in_ready);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    checks++;
    if ({bus.out_valid, bus.out_last, bus.done, bus.in_ready, bus.out_data, bus.out_addr} !==
        {4'b0001, 16'h0000, 16'h0000}) begin
      errors++;
      $display("FAIL reset_state: got valid=%b last=%b done=%b in_ready=%b data=%h addr=%h, expected 0 0 0 1 0000 0000",
               bus.out_valid, bus.out_last, bus.done, bus.in_ready, bus.out_data, bus.out_addr);
    end
    rst = 1'b0;
    idle_check(1);
  endtask

  task automatic test_asc();
    fill_ramp(16'hA000);
    run_burst(16'h0100, 1'b0, 0, 1'b0, 0);
    idle_check(2);
  endtask

  task automatic test_desc();
    fill_ramp(16'hA000);
    run_burst(16'h0100, 1'b1, 0, 1'b0, 0);
    idle_check(1);
  endtask

  task automatic test_stall();
    fill_ramp(16'hA000);
    run_burst(16'h0100, 1'b0, 1, 1'b0, 0);
    idle_check(1);
    fill_random();
    run_burst(16'h2345, 1'b1, 1, 1'b0, 0);
    idle_check(1);
  endtask

  task automatic test_wrap();
    fill_random();
    run_burst(16'hFFFE, 1'b0, 0, 1'b0, 0);
    idle_check(1);
    run_burst(16'hFFF9, 1'b1, 2, 1'b0, 0);
    idle_check(1);
  endtask

  task automatic test_wrap_depth4();
    logic [AW-1:0] exp_a [4] = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    logic [DW-1:0] ed;
    checks++;
    if (bus4.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL d4_ready: in_ready=%b expected 1", bus4.in_ready);
    end
    bus4.in_valid     = 1'b1;
    for (int i = 0; i < 4; i++) bus4.in_data[i] = 16'hB000 + 16'(i);
    bus4.in_base_addr = 16'hFFFE;
    bus4.in_desc      = 1'b0;
    bus4.out_ready    = 1'b1;
    @(posedge clk);
    bus4.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ed = 16'hB000 + 16'(k);
      checks++;
      if ({bus4.out_valid, bus4.out_last, bus4.out_addr, bus4.out_data} !==
          {1'b1, (k == 3), exp_a[k], ed}) begin
        errors++;
        $display("FAIL d4_beat%0d: got valid=%b last=%b addr=%h data=%h, expected 1 %b %h %h",
                 k, bus4.out_valid, bus4.out_last, bus4.out_addr, bus4.out_data, (k == 3), exp_a[k], ed);
      end
      @(posedge clk);
    end
    checks++;
    if ({bus4.done, bus4.out_valid, bus4.in_ready} !== 3'b101) begin
      errors++;
      $display("FAIL d4_done: got done=%b valid=%b in_ready=%b, expected 1 0 1",
               bus4.done, bus4.out_valid, bus4.in_ready);
    end
    bus4.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    fill_random();
    run_burst(AW'($urandom), 1'b0, 0, 1'b0, 5);
    idle_check(3);
    fill_ramp(16'hC000);
    run_burst(16'h0200, 1'b0, 0, 1'b0, 0);
    idle_check(1);
  endtask

  task automatic test_back_to_back();
    fill_ramp(16'h1000);
    run_burst(16'h0300, 1'b0, 0, 1'b1, 0);
    fill_random();
    run_burst(16'h0400, 1'b1, 2, 1'b0, 0);
    idle_check(1);
  endtask

  task automatic test_random();
    repeat (6) begin
      fill_random();
      run_burst(AW'($urandom), 1'($urandom_range(0, 1)), 2, 1'b0, 0);
      idle_check(1);
    end
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_asc();
    test_desc();
    test_stall();
    test_wrap();
    test_wrap_depth4();
    test_reset_mid_burst();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
